// File: rtl/mac16_dotprod_seq.sv
`default_nettype none
// ============================================================================
// Module   : mac16_dotprod_seq
// Brief    : Streams dot-product operand pairs into one MAC16 block and returns
//            the accumulated 32-bit result on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module mac16_dotprod_seq #(
   parameter int          LEN_W    = 8,
   parameter int          MAC_LAT  = 3,
   parameter int          OUT_LAT  = 1,
   parameter logic [24:0] CBIT_CFG = 25'h0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [LEN_W-1:0] LEN,
   input  logic             SUB,
   output logic             BUSY,
   input  logic             OP_VALID,
   output logic             OP_READY,
   input  logic [15:0]      OP_A,
   input  logic [15:0]      OP_B,
   output logic [15:0]      MAC_A,
   output logic [15:0]      MAC_B,
   output logic             MAC_AHLD,
   output logic             MAC_BHLD,
   output logic             MAC_OHHLD,
   output logic             MAC_OLHLD,
   output logic             MAC_OHLDA,
   output logic             MAC_OLLDA,
   output logic             MAC_OHADS,
   output logic             MAC_OLADS,
   output logic [24:0]      MAC_CBIT,
   input  logic [31:0]      MAC_O,
   output logic             RES_VALID,
   input  logic             RES_READY,
   output logic [31:0]      RES
);

   localparam int                 c_cnt_w   = $clog2(OUT_LAT + 2);
   localparam logic [c_cnt_w-1:0] c_out_lat = c_cnt_w'(OUT_LAT);
   localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
   localparam logic [LEN_W-1:0]   c_len_one = LEN_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W-1:0]   r_issued;
   logic               r_sub;
   logic [15:0]        r_mac_a;
   logic [15:0]        r_mac_b;
   logic               r_ab_hld;
   logic [31:0]        r_res;
   logic [MAC_LAT-1:0] r_pipe_v;
   logic [MAC_LAT-1:0] r_pipe_first;
   logic [MAC_LAT-1:0] r_pipe_sub;
   logic [c_cnt_w-1:0] r_drain_cnt;
   logic [c_cnt_w-1:0] w_cnt_nxt;
   logic               w_hs;
   logic               w_last;
   logic               w_capture;
   logic               w_out_v;
   logic               w_upstream_v;
   logic               w_any_v;

   assign OP_READY     = (r_state == S_RUN);
   assign BUSY         = (r_state != S_IDLE);
   assign RES_VALID    = (r_state == S_HOLD);
   assign RES          = r_res;
   assign w_hs         = OP_VALID & OP_READY;
   assign w_last       = w_hs & (r_issued == (r_len - c_len_one));

   assign w_out_v      = r_pipe_v[MAC_LAT-1];
   assign w_any_v      = w_out_v | w_upstream_v;

   // Tokens still travelling towards the accumulator stage
   if (MAC_LAT > 1) begin : g_upstream
      assign w_upstream_v = |r_pipe_v[MAC_LAT-2:0];
   end else begin : g_no_upstream
      assign w_upstream_v = 1'b0;
   end

   assign MAC_A        = r_mac_a;
   assign MAC_B        = r_mac_b;
   assign MAC_AHLD     = r_ab_hld;
   assign MAC_BHLD     = r_ab_hld;
   assign MAC_OHHLD    = ~w_out_v;
   assign MAC_OLHLD    = ~w_out_v;
   assign MAC_OHLDA    = w_out_v & r_pipe_first[MAC_LAT-1];
   assign MAC_OLLDA    = w_out_v & r_pipe_first[MAC_LAT-1];
   assign MAC_OHADS    = w_out_v & r_pipe_sub[MAC_LAT-1];
   assign MAC_OLADS    = w_out_v & r_pipe_sub[MAC_LAT-1];
   assign MAC_CBIT     = CBIT_CFG;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_cnt_nxt   = '0;
      case (r_state)
         S_IDLE: begin
            if (START) begin
               w_state_nxt = (LEN != '0) ? S_RUN : S_HOLD;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_cnt_nxt = r_drain_cnt;
            // The youngest token reaching the output is the final enable
            if (w_out_v && !w_upstream_v) begin
               if (OUT_LAT == 0) begin
                  w_capture = 1'b1;
               end else begin
                  w_cnt_nxt = c_cnt_one;
               end
            end else if (!w_any_v) begin
               if (r_drain_cnt == c_out_lat) begin
                  w_capture = 1'b1;
               end else begin
                  w_cnt_nxt = r_drain_cnt + c_cnt_one;
               end
            end
            if (w_capture) begin
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (RES_READY) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_len        <= '0;
         r_issued     <= '0;
         r_sub        <= 1'b0;
         r_mac_a      <= '0;
         r_mac_b      <= '0;
         r_ab_hld     <= 1'b1;
         r_res        <= '0;
         r_pipe_v     <= '0;
         r_pipe_first <= '0;
         r_pipe_sub   <= '0;
         r_drain_cnt  <= '0;
      end else begin
         r_drain_cnt <= w_cnt_nxt;
         r_ab_hld    <= ~w_hs;
         if ((r_state == S_IDLE) && START) begin
            r_len    <= LEN;
            r_sub    <= SUB;
            r_issued <= '0;
            if (LEN == '0) begin
               r_res <= '0;
            end
         end
         if (w_hs) begin
            r_mac_a  <= OP_A;
            r_mac_b  <= OP_B;
            r_issued <= r_issued + c_len_one;
         end
         for (int i = MAC_LAT - 1; i > 0; i--) begin
            r_pipe_v[i]     <= r_pipe_v[i-1];
            r_pipe_first[i] <= r_pipe_first[i-1];
            r_pipe_sub[i]   <= r_pipe_sub[i-1];
         end
         r_pipe_v[0]     <= w_hs;
         r_pipe_first[0] <= w_hs & (r_issued == '0);
         r_pipe_sub[0]   <= w_hs & r_sub;
         if (w_capture) begin
            r_res <= MAC_O;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mac16_dotprod_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac16_dotprod_seq
// Brief    : Bench for mac16_dotprod_seq with a signed MAC16 model and a
//            dot-product scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac16_dotprod_seq;

   localparam int MAC_LAT = 3;
   localparam int OUT_LAT = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  len = '0;
   logic        sub = 1'b0;
   logic        busy;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic [15:0] op_a = '0;
   logic [15:0] op_b = '0;
   logic [15:0] mac_a, mac_b;
   logic        mac_ahld, mac_bhld, mac_ohhld, mac_olhld;
   logic        mac_ohlda, mac_ollda, mac_ohads, mac_olads;
   logic [24:0] mac_cbit;
   logic [31:0] mac_o;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res;

   mac16_dotprod_seq #(
      .LEN_W(8), .MAC_LAT(MAC_LAT), .OUT_LAT(OUT_LAT), .CBIT_CFG(25'h0)
   ) dut (
      .CLK(clk), .RST(rst), .START(start), .LEN(len), .SUB(sub), .BUSY(busy),
      .OP_VALID(op_valid), .OP_READY(op_ready), .OP_A(op_a), .OP_B(op_b),
      .MAC_A(mac_a), .MAC_B(mac_b), .MAC_AHLD(mac_ahld), .MAC_BHLD(mac_bhld),
      .MAC_OHHLD(mac_ohhld), .MAC_OLHLD(mac_olhld), .MAC_OHLDA(mac_ohlda),
      .MAC_OLLDA(mac_ollda), .MAC_OHADS(mac_ohads), .MAC_OLADS(mac_olads),
      .MAC_CBIT(mac_cbit), .MAC_O(mac_o), .RES_VALID(res_valid),
      .RES_READY(res_ready), .RES(res)
   );

   always #5 clk = ~clk;

   // Signed MAC16: input registers, product register, 32-bit accumulator
   logic signed [15:0] m_a = '0;
   logic signed [15:0] m_b = '0;
   logic signed [31:0] m_p = '0;
   logic [31:0]        m_acc = '0;
   always @(posedge clk) begin
      if (!mac_ahld) m_a <= mac_a;
      if (!mac_bhld) m_b <= mac_b;
      m_p <= m_a * m_b;
      if (!mac_olhld) begin
         if (mac_ollda) m_acc <= mac_olads ? -m_p : m_p;
         else           m_acc <= mac_olads ? m_acc - m_p : m_acc + m_p;
      end
   end
   assign mac_o = m_acc;

   int cyc = 0;
   int en_cnt = 0, lda_cnt = 0, lda_pos_bad = 0, ld_cnt = 0, mis_cnt = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         if (!mac_ohhld) begin
            en_cnt = en_cnt + 1;
            if (mac_ohlda) begin
               lda_cnt = lda_cnt + 1;
               if (en_cnt != 1) lda_pos_bad = lda_pos_bad + 1;
            end
         end
         if (!mac_ahld) ld_cnt = ld_cnt + 1;
         if (mac_ohhld != mac_olhld || mac_ohlda != mac_ollda ||
             mac_ohads != mac_olads || mac_ahld != mac_bhld)
            mis_cnt = mis_cnt + 1;
      end
   end

   int total = 0;
   int bad = 0;
   int hs_cyc = 0;
   int rv_cyc = 0;
   logic [15:0] va [0:255];
   logic [15:0] vb [0:255];

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      en_cnt = 0; lda_cnt = 0; lda_pos_bad = 0; ld_cnt = 0;
   endtask

   function automatic logic [79:0] outvec();
      return {5'b0, busy, op_ready, res_valid, res, mac_a, mac_b,
              mac_ahld, mac_bhld, mac_ohhld, mac_olhld,
              mac_ohlda, mac_ollda, mac_ohads, mac_olads};
   endfunction

   function automatic logic [31:0] ref_dot(input int n, input bit s);
      logic [31:0] acc;
      int p;
      acc = '0;
      for (int k = 0; k < n; k++) begin
         p = int'($signed(va[k])) * int'($signed(vb[k]));
         acc = s ? acc - p : acc + p;
      end
      return acc;
   endfunction

   task automatic issue(input int n, input bit s);
      start = 1'b1; len = 8'(n); sub = s;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // mode 0: valid always high, 1: toggling 1/0, other: random
   task automatic feed(input int n, input int mode);
      int   k = 0;
      int   guard = 0;
      bit   tog = 1'b1;
      logic rdy;
      while (k < n && guard < 4000) begin
         case (mode)
            0:       op_valid = 1'b1;
            1:       begin op_valid = tog; tog = ~tog; end
            default: op_valid = 1'($urandom_range(0, 1));
         endcase
         op_a = va[k]; op_b = vb[k];
         rdy = op_ready;
         @(posedge clk); #1;
         if (op_valid && rdy) begin
            k++;
            hs_cyc = cyc;
         end
         guard++;
      end
      op_valid = 1'b0;
      if (k < n) begin
         total++; bad++;
         $display("FAIL feed_timeout: got %0d terms accepted, required %0d", k, n);
      end
   endtask

   task automatic take_result(input int delay, output logic [31:0] r);
      int g = 0;
      int unstable = 0;
      while (!res_valid && g < 2000) begin
         @(posedge clk); #1;
         g++;
      end
      rv_cyc = cyc;
      r = res;
      if (!res_valid) begin
         total++; bad++;
         $display("FAIL res_timeout: got res_valid=0, required 1");
      end
      for (int i = 0; i < delay; i++) begin
         @(posedge clk); #1;
         if (!res_valid || res !== r) unstable++;
      end
      chk("hold_stable", 80'(unstable), 80'(0));
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   typedef struct {
      int          n;
      bit          s;
      int          mode;
      int          a [4];
      int          b [4];
      logic [31:0] exp;
   } vec_t;

   function automatic vec_t mk(input int n, input bit s, input int mode,
                               input int a0, input int a1, input int a2, input int a3,
                               input int b0, input int b1, input int b2, input int b3,
                               input logic [31:0] exp);
      vec_t v;
      v.n = n; v.s = s; v.mode = mode;
      v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
      v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
      v.exp = exp;
      return v;
   endfunction

   initial begin
      vec_t        vecs [4];
      logic [31:0] r;
      int          n;
      bit          s;

      vecs[0] = mk(3, 1'b0, 0, 2, 4, -1, 0, 3, 5, 7, 0, 32'd19);
      vecs[1] = mk(2, 1'b1, 0, 100, -3, 0, 0, 100, 4, 0, 0, 32'hFFFFD8FC);
      vecs[2] = mk(4, 1'b0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 32'd4);
      vecs[3] = mk(1, 1'b0, 2, 3, 0, 0, 0, 3, 0, 0, 0, 32'd9);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", outvec(), {5'b0, 3'b000, 32'h0, 16'h0, 16'h0, 8'b1111_0000});
      chk("cbit", 80'(mac_cbit), 80'(25'h0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed table
      for (int i = 0; i < 4; i++) begin
         clear_mon();
         for (int k = 0; k < 4; k++) begin
            va[k] = 16'(vecs[i].a[k]);
            vb[k] = 16'(vecs[i].b[k]);
         end
         issue(vecs[i].n, vecs[i].s);
         feed(vecs[i].n, vecs[i].mode);
         take_result(2, r);
         chk($sformatf("vec%0d_res", i), 80'(r), 80'(vecs[i].exp));
         chk($sformatf("vec%0d_enables", i), 80'(en_cnt), 80'(vecs[i].n));
         chk($sformatf("vec%0d_lda_cnt", i), 80'(lda_cnt), 80'(1));
         chk($sformatf("vec%0d_lda_first", i), 80'(lda_pos_bad), 80'(0));
         chk($sformatf("vec%0d_ab_loads", i), 80'(ld_cnt), 80'(vecs[i].n));
         if (vecs[i].mode == 0)
            chk($sformatf("vec%0d_latency", i), 80'(rv_cyc - hs_cyc), 80'(MAC_LAT + OUT_LAT));
         chk($sformatf("vec%0d_idle", i), 80'(busy), 80'(0));
      end

      // Back-to-back with a long result stall and START while busy
      clear_mon();
      va[0] = 16'd1; vb[0] = 16'd2; va[1] = 16'd1; vb[1] = 16'd3;
      issue(2, 1'b0);
      start = 1'b1; len = 8'd9;
      feed(2, 0);
      start = 1'b0;
      take_result(10, r);
      chk("b2b_first_res", 80'(r), 80'(5));
      chk("b2b_first_enables", 80'(en_cnt), 80'(2));
      clear_mon();
      va[0] = 16'd3; vb[0] = 16'd3;
      issue(1, 1'b0);
      feed(1, 0);
      take_result(1, r);
      chk("b2b_second_res", 80'(r), 80'(9));
      chk("b2b_second_enables", 80'(en_cnt), 80'(1));

      // LEN=0 command, then START during the result handshake is not seen
      clear_mon();
      issue(0, 1'b0);
      chk("len0_valid_res", {47'b0, res_valid, res}, {47'b0, 1'b1, 32'h0});
      chk("len0_holds", {76'b0, mac_ahld, mac_bhld, mac_ohhld, mac_olhld}, {76'b0, 4'b1111});
      res_ready = 1'b1; start = 1'b1; len = 8'd0;
      @(posedge clk); #1;
      res_ready = 1'b0; start = 1'b0;
      chk("start_on_return_ignored", 80'(busy), 80'(0));
      chk("len0_no_activity", 80'(en_cnt + ld_cnt), 80'(0));

      // Reset mid-RUN after 2 of 5 terms
      for (int k = 0; k < 5; k++) begin va[k] = 16'(k + 2); vb[k] = 16'(k + 5); end
      issue(5, 1'b0);
      feed(2, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrun_reset", outvec(), {5'b0, 3'b000, 32'h0, 16'h0, 16'h0, 8'b1111_0000});
      rst = 1'b0;
      @(posedge clk); #1;
      clear_mon();
      va[0] = 16'd7; vb[0] = 16'd6;
      issue(1, 1'b0);
      feed(1, 2);
      take_result(0, r);
      chk("after_reset_res", 80'(r), 80'(42));

      // Randomized commands against the dot-product scoreboard
      for (int t = 0; t < 21; t++) begin
         n = (t == 20) ? 255 : $urandom_range(1, 12);
         s = 1'($urandom_range(0, 1));
         for (int k = 0; k < n; k++) begin
            va[k] = 16'($urandom);
            vb[k] = 16'($urandom);
         end
         clear_mon();
         issue(n, s);
         feed(n, 2);
         take_result($urandom_range(0, 3), r);
         chk($sformatf("rand%0d_res", t), 80'(r), 80'(ref_dot(n, s)));
         chk($sformatf("rand%0d_enables", t), 80'(en_cnt), 80'(n));
      end

      chk("lane_consistency", 80'(mis_cnt), 80'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
